// File: rtl/ps2_cmd_sequencer_pkg.sv
// Shared constants, state encoding and sizing helper for the PS/2 command sequencer.
package ps2_cmd_sequencer_pkg;

    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_WAIT_TX  = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Counter width able to hold n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ps2_cmd_sequencer_if.sv
// Transmitter/receiver link between the command sequencer (master) and the PS/2 PHY (slave).
interface ps2_cmd_sequencer_if;
    logic       tx_write;
    logic [7:0] tx_byte;
    logic       tx_idle;
    logic       tx_done;
    logic       rx_done;
    logic [7:0] rx_byte;

    modport master (
        output tx_write, tx_byte,
        input  tx_idle, tx_done, rx_done, rx_byte
    );

    modport slave (
        input  tx_write, tx_byte,
        output tx_idle, tx_done, rx_done, rx_byte
    );
endinterface

// File: rtl/ps2_ack_timer.sv
// Acknowledge timeout counter. Counts down from ACK_TIMEOUT-1 after a clear, so the
// terminal count of zero lands on the same cycle an up-count would reach ACK_TIMEOUT-1.
module ps2_ack_timer
    import ps2_cmd_sequencer_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int                TMR_W   = cnt_width(ACK_TIMEOUT);
    localparam logic [TMR_W-1:0]  TC_LOAD = TMR_W'(ACK_TIMEOUT - 1);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Next count: reload on clear, otherwise step down while enabled and not yet at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = TC_LOAD;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host command sequencer: round-robin arbitration between two requesters,
// byte-at-a-time transmit with ACK/RESEND handling and a per-command retry budget.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | no command; sample req and grant
// ST_SEND     | present byte, strobe tx_write once the transmitter is idle
// ST_WAIT_TX  | frame on the wire, waiting for tx_done
// ST_WAIT_ACK | waiting for device response, timeout timer running
// ST_DONE     | one-cycle done pulse with err, rotate round-robin pointer
module ps2_cmd_sequencer
    import ps2_cmd_sequencer_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1_000_000,
    parameter int MAX_RETRY   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req,
    input  logic [7:0]              cmd0,
    input  logic [7:0]              cmd1,
    input  logic [7:0]              arg0,
    input  logic [7:0]              arg1,
    input  logic [1:0]              has_arg,
    output logic [1:0]              gnt,
    output logic [1:0]              done,
    output logic                    err,
    output logic                    busy,
    ps2_cmd_sequencer_if.master     link
);

    localparam int               RTY_W   = cnt_width(MAX_RETRY + 1);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [7:0]       arg_q, arg_d;
    logic             has_arg_q, has_arg_d;
    logic             arg_phase_q, arg_phase_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic             err_q, err_d;
    logic             rr_q, rr_d;   // 1: requester 1 wins a tie next

    logic             grant_hi;
    logic             tx_write_c;
    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_expired;

    ps2_ack_timer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    assign tmr_en = (state_q == ST_WAIT_ACK);

    // Next-state, arbitration, command latching and response decoding.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        has_arg_d   = has_arg_q;
        arg_phase_d = arg_phase_q;
        retry_d     = retry_q;
        err_d       = err_q;
        rr_d        = rr_q;
        grant_hi    = 1'b0;
        tx_write_c  = 1'b0;
        tmr_clr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    grant_hi    = req[1] && (!req[0] || rr_q);
                    gnt_d       = grant_hi ? 2'b10 : 2'b01;
                    cmd_d       = grant_hi ? cmd1 : cmd0;
                    arg_d       = grant_hi ? arg1 : arg0;
                    has_arg_d   = grant_hi ? has_arg[1] : has_arg[0];
                    retry_d     = '0;
                    arg_phase_d = 1'b0;
                    err_d       = 1'b0;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                if (link.tx_idle) begin
                    tx_write_c = 1'b1;
                    state_d    = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                if (link.tx_done) begin
                    tmr_clr = 1'b1;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // A recognised response beats a simultaneous timeout; other bytes are noise.
                if (link.rx_done && (link.rx_byte == PS2_ACK)) begin
                    if (has_arg_q && !arg_phase_q) begin
                        arg_phase_d = 1'b1;
                        state_d     = ST_SEND;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end
                end else if (link.rx_done && (link.rx_byte == PS2_RESEND)) begin
                    if (retry_q < RTY_MAX) begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = ST_SEND;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                gnt_d   = 2'b00;
                rr_d    = gnt_q[0];
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 2'b00;
            cmd_q       <= 8'h00;
            arg_q       <= 8'h00;
            has_arg_q   <= 1'b0;
            arg_phase_q <= 1'b0;
            retry_q     <= '0;
            err_q       <= 1'b0;
            rr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            cmd_q       <= cmd_d;
            arg_q       <= arg_d;
            has_arg_q   <= has_arg_d;
            arg_phase_q <= arg_phase_d;
            retry_q     <= retry_d;
            err_q       <= err_d;
            rr_q        <= rr_d;
        end
    end

    assign gnt           = gnt_q;
    assign done          = (state_q == ST_DONE) ? gnt_q : 2'b00;
    assign err           = (state_q == ST_DONE) && err_q;
    assign busy          = (state_q != ST_IDLE);
    assign link.tx_write = tx_write_c;
    assign link.tx_byte  = arg_phase_q ? arg_q : cmd_q;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Bench for ps2_cmd_sequencer: a transmitter/device model answers from a response queue,
// transmitted bytes and completions are checked against scoreboard queues.
module tb_ps2_cmd_sequencer;

    localparam int ACK_TO = 16;
    localparam int MAXR   = 2;
    localparam int TX_LAT = 3;

    typedef struct {
        logic [1:0] pat;
        logic       err;
        bit         from_txd;
        int         lat;
    } done_exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [7:0] cmd0, cmd1, arg0, arg1;
    logic [1:0] has_arg;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       err;
    logic       busy;

    ps2_cmd_sequencer_if link();

    ps2_cmd_sequencer #(
        .ACK_TIMEOUT (ACK_TO),
        .MAX_RETRY   (MAXR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .cmd0    (cmd0),
        .cmd1    (cmd1),
        .arg0    (arg0),
        .arg1    (arg1),
        .has_arg (has_arg),
        .gnt     (gnt),
        .done    (done),
        .err     (err),
        .busy    (busy),
        .link    (link)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_tx_q[$];
    done_exp_t  exp_done_q[$];
    int         resp_q[$];
    int         resp_dly = 10;

    int checks = 0;
    int errors = 0;

    int tx_seen      = 0;
    int tx_first_cyc = -1;
    int txd_cyc      = 0;
    int rx_cyc       = 0;
    int req_cyc      = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_done(input logic [1:0] pat, input logic e, input bit from_txd, input int lat);
        done_exp_t d;
        d.pat      = pat;
        d.err      = e;
        d.from_txd = from_txd;
        d.lat      = lat;
        exp_done_q.push_back(d);
    endtask

    task automatic issue(input logic [1:0] r);
        tx_seen      = 0;
        tx_first_cyc = -1;
        req_cyc      = cyc;
        req          = r;
    endtask

    task automatic wait_done(input string tag);
        int  n   = 0;
        bit  got = 1'b0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (done != 2'b00) got = 1'b1;
        end
        check_val(tag, {31'd0, got}, 32'd1);
    endtask

    // Transmitter and device model: samples at negedge, drives just after posedge.
    initial begin
        int        tx_cnt;
        int        rx_cnt;
        int        rx_val;
        bit        rx_pend;
        bit        start_tx;
        done_exp_t e;
        tx_cnt  = 0;
        rx_cnt  = 0;
        rx_val  = 0;
        rx_pend = 1'b0;
        link.tx_idle = 1'b1;
        link.tx_done = 1'b0;
        link.rx_done = 1'b0;
        link.rx_byte = 8'h00;
        forever begin
            @(negedge clk);
            start_tx = 1'b0;
            if (!rst && link.tx_write) begin
                start_tx = 1'b1;
                tx_seen++;
                if (tx_first_cyc < 0) tx_first_cyc = cyc;
                if (exp_tx_q.size() == 0)
                    check_val("tx_unexpected", {31'd0, link.tx_write}, 32'd0);
                else
                    check_val("tx_byte", {24'd0, link.tx_byte}, {24'd0, exp_tx_q.pop_front()});
            end
            if (!rst && done != 2'b00) begin
                if (exp_done_q.size() == 0) begin
                    check_val("done_unexpected", {30'd0, done}, 32'd0);
                end else begin
                    e = exp_done_q.pop_front();
                    check_val("done_pat", {30'd0, done}, {30'd0, e.pat});
                    check_val("done_err", {31'd0, err}, {31'd0, e.err});
                    check_val("done_lat", cyc - (e.from_txd ? txd_cyc : rx_cyc), e.lat);
                end
            end
            @(posedge clk);
            #1;
            link.tx_done = 1'b0;
            link.rx_done = 1'b0;
            if (rst) begin
                tx_cnt       = 0;
                rx_pend      = 1'b0;
                link.tx_idle = 1'b1;
            end else begin
                if (rx_pend) begin
                    rx_cnt--;
                    if (rx_cnt == 0) begin
                        link.rx_done = 1'b1;
                        link.rx_byte = rx_val[7:0];
                        rx_cyc       = cyc;
                        rx_pend      = 1'b0;
                    end
                end
                if (start_tx) begin
                    link.tx_idle = 1'b0;
                    tx_cnt       = TX_LAT;
                end else if (tx_cnt > 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) begin
                        link.tx_done = 1'b1;
                        link.tx_idle = 1'b1;
                        txd_cyc      = cyc;
                        if (resp_q.size() > 0) begin
                            rx_val  = resp_q.pop_front();
                            rx_cnt  = resp_dly;
                            rx_pend = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        int n;
        rst     = 1'b1;
        req     = 2'b00;
        cmd0    = 8'h00;
        cmd1    = 8'h00;
        arg0    = 8'h00;
        arg1    = 8'h00;
        has_arg = 2'b00;
        repeat (3) @(negedge clk);
        check_val("rst_gnt", {30'd0, gnt}, 32'd0);
        check_val("rst_done", {30'd0, done}, 32'd0);
        check_val("rst_err", {31'd0, err}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_tx_write", {31'd0, link.tx_write}, 32'd0);
        check_val("rst_tx_byte", {24'd0, link.tx_byte}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single-byte command, ACK after 10 cycles.
        cmd0 = 8'hFF;
        exp_tx_q.push_back(8'hFF);
        resp_q.push_back(32'hFA);
        push_done(2'b01, 1'b0, 1'b0, 1);
        issue(2'b01);
        @(negedge clk);
        check_val("t1_gnt", {30'd0, gnt}, 32'd1);
        check_val("t1_busy", {31'd0, busy}, 32'd1);
        wait_done("t1_done_seen");
        req = 2'b00;
        check_val("t1_gnt_hold", {30'd0, gnt}, 32'd1);
        check_val("t1_tx_count", tx_seen, 1);
        check_val("t1_tx_latency", tx_first_cyc - req_cyc, 1);
        @(negedge clk);
        check_val("t1_idle_busy", {31'd0, busy}, 32'd0);
        check_val("t1_idle_gnt", {30'd0, gnt}, 32'd0);

        // Two resends then ACK.
        cmd0 = 8'hF4;
        arg0 = 8'h55;
        repeat (3) exp_tx_q.push_back(8'hF4);
        resp_q.push_back(32'hFE);
        resp_q.push_back(32'hFE);
        resp_q.push_back(32'hFA);
        push_done(2'b01, 1'b0, 1'b0, 1);
        issue(2'b01);
        wait_done("t3_done_seen");
        req = 2'b00;
        check_val("t3_tx_count", tx_seen, 3);
        @(negedge clk);

        // Retries exhausted.
        repeat (3) exp_tx_q.push_back(8'hF4);
        repeat (3) resp_q.push_back(32'hFE);
        push_done(2'b01, 1'b1, 1'b0, 1);
        issue(2'b01);
        wait_done("t4_done_seen");
        req = 2'b00;
        check_val("t4_tx_count", tx_seen, 3);
        @(negedge clk);

        // Ignored byte then silence: timeout measured from tx_done.
        exp_tx_q.push_back(8'hF4);
        resp_q.push_back(32'hAA);
        push_done(2'b01, 1'b1, 1'b1, ACK_TO + 1);
        issue(2'b01);
        wait_done("t5_done_seen");
        req = 2'b00;
        check_val("t5_tx_count", tx_seen, 1);
        @(negedge clk);

        // Command with argument byte from requester 1.
        cmd1    = 8'hED;
        arg1    = 8'h07;
        has_arg = 2'b10;
        exp_tx_q.push_back(8'hED);
        exp_tx_q.push_back(8'h07);
        resp_q.push_back(32'hFA);
        resp_q.push_back(32'hFA);
        push_done(2'b10, 1'b0, 1'b0, 1);
        issue(2'b10);
        @(negedge clk);
        check_val("t2_gnt", {30'd0, gnt}, 32'd2);
        wait_done("t2_done_seen");
        req = 2'b00;
        check_val("t2_tx_count", tx_seen, 2);
        @(negedge clk);

        // Both requesting continuously: alternate, then reset mid-frame.
        cmd0    = 8'hF5;
        cmd1    = 8'hF6;
        has_arg = 2'b00;
        exp_tx_q.push_back(8'hF5);
        exp_tx_q.push_back(8'hF6);
        exp_tx_q.push_back(8'hF5);
        exp_tx_q.push_back(8'hF6);
        repeat (3) resp_q.push_back(32'hFA);
        push_done(2'b01, 1'b0, 1'b0, 1);
        push_done(2'b10, 1'b0, 1'b0, 1);
        push_done(2'b01, 1'b0, 1'b0, 1);
        issue(2'b11);
        wait_done("rr0_done_seen");
        check_val("rr0_gnt", {30'd0, gnt}, 32'd1);
        wait_done("rr1_done_seen");
        check_val("rr1_gnt", {30'd0, gnt}, 32'd2);
        wait_done("rr2_done_seen");
        check_val("rr2_gnt", {30'd0, gnt}, 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (link.tx_idle && n < 50);
        check_val("rr3_in_wait_tx", {31'd0, link.tx_idle}, 32'd0);
        check_val("rr3_gnt", {30'd0, gnt}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_val("rst_mid_gnt", {30'd0, gnt}, 32'd0);
        check_val("rst_mid_tx_write", {31'd0, link.tx_write}, 32'd0);
        check_val("rst_mid_done", {30'd0, done}, 32'd0);
        exp_tx_q.delete();
        resp_q.delete();
        exp_done_q.delete();
        exp_tx_q.push_back(8'hF5);
        resp_q.push_back(32'hFA);
        push_done(2'b01, 1'b0, 1'b0, 1);
        rst = 1'b0;
        tx_seen      = 0;
        tx_first_cyc = -1;
        @(negedge clk);
        check_val("post_rst_gnt", {30'd0, gnt}, 32'd1);
        wait_done("post_rst_done_seen");
        req = 2'b00;
        check_val("post_rst_tx_count", tx_seen, 1);
        repeat (3) @(negedge clk);

        check_val("tx_queue_drained", exp_tx_q.size(), 0);
        check_val("done_queue_drained", exp_done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ps2_cmd_sequencer.md
# ps2_cmd_sequencer

Host-side command sequencer for the PS/2 transmit path. It arbitrates between two command requesters and drives the transmitter's write strobe and byte one byte at a time. After each byte it waits for the device's acknowledge on the receive path. It resends on a resend request (0xFE) and reports completion or failure per command, including two-byte commands such as 0xED + LED mask.

## Interface
- ACK_TIMEOUT, 1_000_000: cycles to wait for a device response after tx_done (20 ms at 50 MHz).
- MAX_RETRY, 2: resends allowed per command before failure.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  2  per-requester command request; level, held until own done
- cmd0, cmd1  in  8  command byte of requester 0/1
- arg0, arg1  in  8  argument byte of requester 0/1
- has_arg  in  2  requester's command carries an argument byte
- gnt  out  2  one-hot grant; held from grant through done cycle
- done  out  2  one-cycle completion pulse to granted requester
- err  out  1  valid with done: 1 = failed (timeout or retries exhausted)
- busy  out  1  high whenever state ≠ IDLE
- tx_write  out  1  one-cycle strobe to the transmitter
- tx_byte  out  8  byte to transmit
- tx_idle  in  1  transmitter idle
- tx_done  in  1  transmitter frame-complete pulse
- rx_done  in  1  receiver byte-valid pulse
- rx_byte  in  8  received byte

## Operation
- Reset: all outputs 0, state IDLE, round-robin pointer favours requester 0, retry count 0, timer 0.
- IDLE: sample req.
  - Exactly one bit set: grant it.
  - Both set: grant the requester not served last.
  - On grant, latch cmd/arg/has_arg into internal registers, clear the retry count, clear the arg phase, go to SEND.
- SEND:
  - tx_byte = latched cmd, or latched arg when in the arg phase.
  - When tx_idle=1: assert tx_write for one cycle, go to WAIT_TX.
  - When tx_idle=0: wait, with no strobe.
- WAIT_TX: on tx_done, clear the timer and go to WAIT_ACK. rx_done is ignored in this state.
- WAIT_ACK: the timer increments each cycle.
  - rx_done with 0xFA:
    - If has_arg is set and the arg phase is not yet set: set the arg phase, go to SEND.
    - Otherwise: go to DONE with err=0.
  - rx_done with 0xFE:
    - If retry count < MAX_RETRY: increment it and go to SEND with the same byte and phase.
    - Otherwise: go to DONE with err=1.
  - rx_done with any other byte: ignored; the timer keeps running.
  - Timer reaches ACK_TIMEOUT-1 with no rx_done: go to DONE with err=1.
  - rx_done and timer expiry in the same cycle: rx_done wins.
- DONE: pulse done[granted]=1 and drive err. Update the round-robin pointer. Go to IDLE; gnt drops on entry to IDLE.
- Request handling:
  - Deasserting req mid-command does not abort; the command runs to completion.
  - A req still high in the IDLE cycle after DONE counts as a new request.
- Reset mid-command returns to IDLE immediately. Any in-flight frame on the transmitter is abandoned by its own reset.

## Timing
- req sampled in IDLE at cycle N gives gnt=1 at N+1. tx_write appears at N+1 at the earliest (tx_idle=1).
- tx_byte is stable from SEND entry until WAIT_ACK is left. gnt is stable for the whole command.
- From the response to the next action:
  - ACK to next tx_write: 1 cycle minimum (WAIT_ACK→SEND).
  - Final ACK to done: done is asserted the cycle after rx_done.
- Timeout: done/err asserted ACK_TIMEOUT+1 cycles after tx_done.
- Retries are counted per command, not per byte. The worst case is MAX_RETRY+1 transmissions of a byte.

## Structure
- Shared header ps2_defs.vh holds:
  - PS2_ACK = 8'hFA, PS2_RESEND = 8'hFE
  - state encodings IDLE/SEND/WAIT_TX/WAIT_ACK/DONE
  - timer width as $clog2(ACK_TIMEOUT)
- Sub-module ps2_ack_timer: clear, enable, and expired at ACK_TIMEOUT-1. It is a counter in the style of the existing 100 µs counter.
- The FSM, arbiter and latch registers live in the top level.

## Test plan
- req=01, cmd0=0xFF, has_arg=0; device answers 0xFA 10 cycles after tx_done:
  - gnt=01 at N+1, one tx_write with tx_byte=0xFF
  - done=01, err=0 one cycle after rx_done
- req=10, cmd1=0xED, arg1=0x07, has_arg=10; ACK after each byte:
  - two tx_write strobes, bytes 0xED then 0x07
  - done=10, err=0
- cmd0=0xF4; device answers 0xFE, 0xFE, then 0xFA:
  - three transmissions of 0xF4, done err=0
- cmd0=0xF4; device answers 0xFE three times:
  - three transmissions, done err=1
- Device answers 0xAA (ignored), then nothing:
  - done err=1 exactly ACK_TIMEOUT+1 cycles after tx_done (use ACK_TIMEOUT=16 in sim)
- req=11 held continuously:
  - grants alternate 01,10,01
  - rst asserted during WAIT_TX: next cycle busy=0, gnt=00, tx_write=0, and a fresh grant goes to requester 0
